// File: rtl/blink_round_ctrl.sv
// -----------------------------------------------------------------------------
// blink_round_ctrl
//
// Round sequencer for the Blink reaction game. Each round is an LED-off gap
// followed by a reaction window with the LED lit. A fresh button press inside
// the window scores a point; a press during the gap (false start) or letting
// the window run out ends play with the lose flag set. The game FSM feeds
// end_cond back to stop play on a win or loss.
//
// Configuration macro: BLINK_SPEEDUP_EN
//   defined   - window length shrinks by SHRINK ticks per point scored, never
//               below MIN_WINDOW ticks.
//   undefined - window length is always ON_TICKS ticks.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   start      in   debounced start/restart level (rising edge = go)
//   btn        in   debounced player button level (rising edge = press)
//   end_cond   in   game over from the game FSM
//   led        out  target LED, high during the reaction window
//   x          out  4-bit score
//   lose       out  miss / false-start flag
//   hit_pulse  out  one-cycle strobe per scored hit
//   dbg_state  out  current round state (IDLE=0 GAP=1 WINDOW=2 HIT=3 MISS=4)
//
// All outputs are registered from the next-state logic, so they line up with
// the state register: led is high exactly in the cycles the FSM is in WINDOW.
// -----------------------------------------------------------------------------
module blink_round_ctrl #(
    parameter int TICK_DIV   = 4,
    parameter int GAP_TICKS  = 4,
    parameter int ON_TICKS   = 8,
    parameter int MIN_WINDOW = 3,
    parameter int SHRINK     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       btn,
    input  logic       end_cond,
    output logic       led,
    output logic [3:0] x,
    output logic       lose,
    output logic       hit_pulse,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GAP    = 3'd1,
        S_WINDOW = 3'd2,
        S_HIT    = 3'd3,
        S_MISS   = 3'd4
    } state_e;

    localparam int            PRE_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [7:0]    GAP_T     = 8'(GAP_TICKS);
    localparam logic [7:0]    ON_T      = 8'(ON_TICKS);

    state_e            state_q, state_d;
    logic              btn_q, start_q;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [3:0]        x_q, x_d;
    logic              lose_q, lose_d;
    logic              led_q, hit_q;

    logic              press, go, tick, last_tick, entering;
    logic [7:0]        win_len;

    assign press     = btn & ~btn_q;
    assign go        = start & ~start_q;
    assign tick      = (pre_q == PRE_LAST);
    // The tick that would take the counter to zero ends the phase.
    assign last_tick = tick && (cnt_q <= 8'd1);

`ifdef BLINK_SPEEDUP_EN
    localparam logic [7:0] SHRINK_T = 8'(SHRINK);
    localparam logic [7:0] MIN_T    = 8'(MIN_WINDOW);

    logic [7:0] shrink_amt;
    logic [7:0] win_raw;

    assign shrink_amt = SHRINK_T * {4'd0, x_q};
    assign win_raw    = ON_T - shrink_amt;
    // Clamp before the subtraction can wrap, then apply the floor.
    assign win_len    = ((shrink_amt >= ON_T) || (win_raw < MIN_T)) ? MIN_T : win_raw;
`else
    logic unused_cfg;

    assign win_len    = ON_T;
    assign unused_cfg = ^{8'(SHRINK), 8'(MIN_WINDOW)};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            btn_q     <= 1'b0;
            start_q   <= 1'b0;
            pre_q     <= '0;
            cnt_q     <= '0;
            x_q       <= '0;
            lose_q    <= 1'b0;
            led_q     <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            btn_q     <= btn;
            start_q   <= start;
            pre_q     <= pre_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            lose_q    <= lose_d;
            led_q     <= (state_d == S_WINDOW);
            hit_q     <= (state_d == S_HIT);
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        lose_d  = lose_q;
        pre_d   = pre_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_GAP;
                    x_d     = 4'd0;
                    lose_d  = 1'b0;
                end
            end
            S_GAP: begin
                if (end_cond) begin
                    state_d = S_IDLE;
                end else if (press) begin
                    state_d = S_MISS;
                    lose_d  = 1'b1;
                end else if (last_tick) begin
                    state_d = S_WINDOW;
                end
            end
            S_WINDOW: begin
                // A press on the expiring tick still counts as a hit.
                if (end_cond) begin
                    state_d = S_IDLE;
                end else if (press) begin
                    state_d = S_HIT;
                    x_d     = (x_q == 4'hF) ? x_q : x_q + 4'd1;
                end else if (last_tick) begin
                    state_d = S_MISS;
                    lose_d  = 1'b1;
                end
            end
            S_HIT: begin
                state_d = end_cond ? S_IDLE : S_GAP;
            end
            S_MISS: begin
                if (go) begin
                    state_d = S_GAP;
                    x_d     = 4'd0;
                    lose_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Restart the prescaler on every phase entry so a phase of N ticks
        // lasts exactly N*TICK_DIV cycles.
        entering = ((state_d == S_GAP) || (state_d == S_WINDOW)) && (state_d != state_q);
        if (entering) begin
            pre_d = '0;
            cnt_d = (state_d == S_GAP) ? GAP_T : win_len;
        end else if ((state_q == S_GAP) || (state_q == S_WINDOW)) begin
            pre_d = tick ? '0 : pre_q + PRE_W'(1);
            if (tick && (cnt_q != 8'd0)) begin
                cnt_d = cnt_q - 8'd1;
            end
        end
    end

    assign led       = led_q;
    assign x         = x_q;
    assign lose      = lose_q;
    assign hit_pulse = hit_q;
    assign dbg_state = state_q;

endmodule
